// File: rtl/bitonic_merge_be_n.sv
// rtl/bitonic_merge_be_n.sv - pipelined bitonic merge backend for N = 2**LOG2N tagged lanes
//
// Merges two equally-sorted halves of x_i into one sorted vector (ascending when
// desc_i = 0, descending when desc_i = 1). One compare-exchange stage per
// register bank, LOG2N banks in total, so a beat takes LOG2N cycles to cross.
// Tags ride with their keys; ctrl and desc ride with the beat. A single global
// enable stalls every bank at once when the output is held by ready_i.
//
// Ports:
//   clk_i, rst_i       clock (rising edge), asynchronous active-high reset
//   valid_i, ready_o   input handshake; ready_o = ready_i | ~valid_o
//   desc_i, ctrl_i     per-beat direction and sideband
//   x_i, tag_i         N keys (two sorted halves) and N tags
//   valid_o, ready_i   output handshake
//   desc_o, ctrl_o     direction and sideband of the emitted beat
//   y_o, tag_o         sorted keys and the correspondingly permuted tags

package sorter_pkg;
    typedef struct packed {
        logic [3:0] id;
        logic       last;
    } ctrl_t;
endpackage

module bitonic_merge_be_n
    import sorter_pkg::*;
#(
    parameter int LOG2N     = 5,
    parameter int DATAWIDTH = 8,
    parameter int TAGWIDTH  = 5,
    parameter int SIGNED    = 0,
    localparam int N        = 1 << LOG2N
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              valid_i,
    output logic                              ready_o,
    input  logic                              desc_i,
    input  ctrl_t                             ctrl_i,
    input  logic [N-1:0][DATAWIDTH-1:0]       x_i,
    input  logic [N-1:0][TAGWIDTH-1:0]        tag_i,
    output logic                              valid_o,
    input  logic                              ready_i,
    output logic                              desc_o,
    output ctrl_t                             ctrl_o,
    output logic [N-1:0][DATAWIDTH-1:0]       y_o,
    output logic [N-1:0][TAGWIDTH-1:0]        tag_o
);

    localparam int LAST = LOG2N - 1;

    typedef logic [N-1:0][DATAWIDTH-1:0] key_vec_t;
    typedef logic [N-1:0][TAGWIDTH-1:0]  tag_vec_t;

    logic enable;

    function automatic logic key_gt(input logic [DATAWIDTH-1:0] a,
                                    input logic [DATAWIDTH-1:0] b);
        if (SIGNED != 0) begin
            return $signed(a) > $signed(b);
        end
        return a > b;
    endfunction

    // The whole pipe moves together unless the last bank holds a beat that
    // downstream is refusing; bubbles in between are kept, never squeezed.
    assign enable  = ready_i | ~stg[LAST].valid_q;
    assign ready_o = enable;

    for (genvar s = 0; s < LOG2N; s++) begin : stg
        // Stage 0 folds lane i against lane N-1-i (turns two like-sorted halves
        // into a bitonic pair); later stages are plain half-cleaners at distance D.
        localparam int D = N >> (s + 1);

        logic     valid_in, desc_in;
        ctrl_t    ctrl_in;
        key_vec_t key_in, key_nx;
        tag_vec_t tag_in, tag_nx;

        logic     valid_q, desc_q;
        ctrl_t    ctrl_q;
        key_vec_t key_q;
        tag_vec_t tag_q;

        if (s == 0) begin : g_src
            assign valid_in = valid_i & ready_o;
            assign desc_in  = desc_i;
            assign ctrl_in  = ctrl_i;
            assign key_in   = x_i;
            assign tag_in   = tag_i;
        end else begin : g_src
            assign valid_in = stg[s-1].valid_q;
            assign desc_in  = stg[s-1].desc_q;
            assign ctrl_in  = stg[s-1].ctrl_q;
            assign key_in   = stg[s-1].key_q;
            assign tag_in   = stg[s-1].tag_q;
        end

        for (genvar j = 0; j < N; j++) begin : lane
            localparam int HI    = (s == 0) ? (N - 1 - j) : (j + D);
            localparam bit IS_LO = (s == 0) ? (j < N / 2) : ((j % (2 * D)) < D);

            if (IS_LO) begin : g_ce
                logic swap;
                // Strict comparison: equal keys stay put, keeping tag order stable.
                assign swap        = desc_in ? key_gt(key_in[HI], key_in[j])
                                             : key_gt(key_in[j], key_in[HI]);
                assign key_nx[j]   = swap ? key_in[HI] : key_in[j];
                assign key_nx[HI]  = swap ? key_in[j]  : key_in[HI];
                assign tag_nx[j]   = swap ? tag_in[HI] : tag_in[j];
                assign tag_nx[HI]  = swap ? tag_in[j]  : tag_in[HI];
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                valid_q <= 1'b0;
                desc_q  <= 1'b0;
                ctrl_q  <= '0;
                key_q   <= '0;
                tag_q   <= '0;
            end else if (enable) begin
                valid_q <= valid_in;
                desc_q  <= desc_in;
                ctrl_q  <= ctrl_in;
                key_q   <= key_nx;
                tag_q   <= tag_nx;
            end
        end
    end

    assign valid_o = stg[LAST].valid_q;
    assign desc_o  = stg[LAST].desc_q;
    assign ctrl_o  = stg[LAST].ctrl_q;
    assign y_o     = stg[LAST].key_q;
    assign tag_o   = stg[LAST].tag_q;

endmodule

// File: tb/tb_bitonic_merge_be_n.sv
// tb/tb_bitonic_merge_be_n.sv - self-checking bench for bitonic_merge_be_n
module tb_bitonic_merge_be_n;
    import sorter_pkg::*;

    localparam int LOG2N = 3;
    localparam int N     = 8;
    localparam int DW    = 8;
    localparam int TW    = 3;

    typedef logic [N-1:0][DW-1:0] kvec_t;
    typedef logic [N-1:0][TW-1:0] tvec_t;

    typedef struct {
        kvec_t xu;
        kvec_t xs;
        logic  desc;
        ctrl_t ctrl;
        int    adv;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  valid_i = 1'b0;
    logic  desc_i = 1'b0;
    logic  ready_i = 1'b1;
    ctrl_t ctrl_i = '0;
    kvec_t x_u = '0;
    kvec_t x_s = '0;
    tvec_t tag_i;

    logic  ready_o_u, valid_o_u, desc_o_u;
    ctrl_t ctrl_o_u;
    kvec_t y_u;
    tvec_t tag_o_u;
    logic  ready_o_s, valid_o_s, desc_o_s;
    ctrl_t ctrl_o_s;
    kvec_t y_s;
    tvec_t tag_o_s;

    int    total = 0;
    int    bad = 0;
    int    emitted = 0;
    bit    done = 0;
    beat_t q[$];
    bit    stall_prev = 0;
    kvec_t prev_y;
    tvec_t prev_t;

    always #5 clk = ~clk;

    bitonic_merge_be_n #(.LOG2N(LOG2N), .DATAWIDTH(DW), .TAGWIDTH(TW), .SIGNED(0)) u_dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o_u),
        .desc_i(desc_i), .ctrl_i(ctrl_i), .x_i(x_u), .tag_i(tag_i),
        .valid_o(valid_o_u), .ready_i(ready_i), .desc_o(desc_o_u),
        .ctrl_o(ctrl_o_u), .y_o(y_u), .tag_o(tag_o_u)
    );

    bitonic_merge_be_n #(.LOG2N(LOG2N), .DATAWIDTH(DW), .TAGWIDTH(TW), .SIGNED(1)) s_dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o_s),
        .desc_i(desc_i), .ctrl_i(ctrl_i), .x_i(x_s), .tag_i(tag_i),
        .valid_o(valid_o_s), .ready_i(ready_i), .desc_o(desc_o_s),
        .ctrl_o(ctrl_o_s), .y_o(y_s), .tag_o(tag_o_s)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic kvec_t kv(input int a [N]);
        kvec_t r;
        for (int i = 0; i < N; i++) r[i] = DW'(a[i]);
        return r;
    endfunction

    function automatic tvec_t tv(input int a [N]);
        tvec_t r;
        for (int i = 0; i < N; i++) r[i] = TW'(a[i]);
        return r;
    endfunction

    function automatic int kval(input logic [DW-1:0] k, input bit sgn);
        if (sgn) return int'($signed(k));
        return int'(k);
    endfunction

    // Plain bubble sort of lanes lo..lo+n-1 in the requested direction.
    function automatic kvec_t sort_rng(input kvec_t v, input int lo, input int n,
                                       input bit desc, input bit sgn);
        kvec_t r = v;
        logic [DW-1:0] t;
        for (int a = 0; a < n; a++) begin
            for (int b = lo; b < lo + n - 1; b++) begin
                bit gt_ = kval(r[b], sgn) > kval(r[b+1], sgn);
                bit lt_ = kval(r[b], sgn) < kval(r[b+1], sgn);
                if (desc ? lt_ : gt_) begin
                    t = r[b]; r[b] = r[b+1]; r[b+1] = t;
                end
            end
        end
        return r;
    endfunction

    // Tags are input lane numbers: they must form a permutation and each must
    // point at the input lane holding the key found in that output lane.
    function automatic bit tags_ok(input kvec_t x, input kvec_t y, input tvec_t t);
        bit [N-1:0] seen = '0;
        for (int i = 0; i < N; i++) begin
            if (seen[t[i]]) return 1'b0;
            seen[t[i]] = 1'b1;
            if (x[t[i]] !== y[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        beat_t b;
        bit exp_v;
        bit en;
        if (rst) begin
            q.delete();
            stall_prev = 0;
            chk("reset_valid_o", {valid_o_u, valid_o_s}, 2'b00);
            chk("reset_ready_o", {ready_o_u, ready_o_s}, 2'b11);
        end else begin
            exp_v = (q.size() > 0) && (q[0].adv == LOG2N - 1);
            chk("valid_o", {valid_o_u, valid_o_s}, {exp_v, exp_v});
            chk("ready_o", {ready_o_u, ready_o_s}, {2{ready_i | ~exp_v}});
            if (stall_prev) begin
                chk("hold_y", y_u, prev_y);
                chk("hold_tag", tag_o_u, prev_t);
            end
            if (exp_v) begin
                b = q[0];
                chk("y_u", y_u, sort_rng(b.xu, 0, N, b.desc, 0));
                chk("y_s", y_s, sort_rng(b.xs, 0, N, b.desc, 1));
                chk("tag_u", tags_ok(b.xu, y_u, tag_o_u), 1);
                chk("tag_s", tags_ok(b.xs, y_s, tag_o_s), 1);
                chk("desc_o", {desc_o_u, desc_o_s}, {2{b.desc}});
                chk("ctrl_o", {ctrl_o_u, ctrl_o_s}, {2{b.ctrl}});
            end
            stall_prev = valid_o_u & ~ready_i;
            prev_y = y_u;
            prev_t = tag_o_u;
            en = ready_i | ~exp_v;
            if (en) begin
                if (exp_v && ready_i) begin
                    void'(q.pop_front());
                    emitted++;
                end
                foreach (q[i]) q[i].adv++;
                if (valid_i) begin
                    b.xu = x_u; b.xs = x_s; b.desc = desc_i; b.ctrl = ctrl_i; b.adv = 0;
                    q.push_back(b);
                end
            end
        end
    end

    task automatic align;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input kvec_t xu, input kvec_t xs, input logic d, input ctrl_t c);
        int n;
        x_u = xu; x_s = xs; desc_i = d; ctrl_i = c; valid_i = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ready_o_u && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o_u) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid_o_u && n < 50);
        if (!valid_o_u) chk("wait_out_timeout", 0, 1);
    endtask

    initial begin
        int    lat;
        int    e0;
        kvec_t v1, v2, v5, vs4, a;
        tvec_t t12;
        bit    d;

        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int    lat;
        int    e0;
        kvec_t v1, v2, v5, vs4, a;
        tvec_t t12;
        bit    d;

        for (int i = 0; i < N; i++) tag_i[i] = TW'(i);
        v1  = kv('{1, 4, 6, 9, 2, 3, 7, 8});
        v2  = kv('{9, 6, 4, 1, 8, 7, 3, 2});
        v5  = kv('{5, 5, 5, 5, 5, 5, 5, 5});
        vs4 = kv('{128, 255, 1, 127, 128, 255, 1, 127});
        t12 = tv('{0, 4, 5, 1, 2, 6, 7, 3});

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("model_asc", sort_rng(v1, 0, N, 0, 0), kv('{1, 2, 3, 4, 6, 7, 8, 9}));
        chk("model_signed", sort_rng(vs4, 0, N, 0, 1), kv('{128, 128, 255, 255, 1, 1, 127, 127}));

        // 1: ascending merge, latency
        send(v1, v1, 1'b0, ctrl_t'(5'd1));
        wait_out(lat);
        chk("t1_latency", lat, LOG2N);
        chk("t1_y", y_u, kv('{1, 2, 3, 4, 6, 7, 8, 9}));
        chk("t1_tag", tag_o_u, t12);
        align();

        // 2: descending merge
        send(v2, v2, 1'b1, ctrl_t'(5'd2));
        wait_out(lat);
        chk("t2_y", y_u, kv('{9, 8, 7, 6, 4, 3, 2, 1}));
        chk("t2_tag", tag_o_u, t12);
        align();

        // 3: back-to-back, alternating direction
        send(v1, v1, 1'b0, ctrl_t'(5'd3));
        send(v2, v2, 1'b1, ctrl_t'(5'd4));
        wait_out(lat);
        chk("t3_first_y", y_u, kv('{1, 2, 3, 4, 6, 7, 8, 9}));
        @(negedge clk);
        chk("t3_second_valid", valid_o_u, 1);
        chk("t3_second_y", y_u, kv('{9, 8, 7, 6, 4, 3, 2, 1}));
        chk("t3_second_desc", desc_o_u, 1);
        align();

        // 4: ties (unsigned instance) and signedness (signed instance)
        send(v5, vs4, 1'b0, ctrl_t'(5'd5));
        wait_out(lat);
        chk("t4_tie_tag", tag_o_u, tv('{0, 1, 2, 3, 4, 5, 6, 7}));
        chk("t4_signed_y", y_s, kv('{128, 128, 255, 255, 1, 1, 127, 127}));
        align();

        // 5: backpressure with 4 beats
        repeat (4) @(negedge clk);
        align();
        e0 = emitted;
        ready_i = 1'b0;
        fork
            begin
                send(v1, v1, 1'b0, ctrl_t'(5'd6));
                send(v2, v2, 1'b1, ctrl_t'(5'd7));
                send(v1, v1, 1'b0, ctrl_t'(5'd8));
                send(v2, v2, 1'b1, ctrl_t'(5'd9));
            end
            begin
                repeat (6) @(posedge clk);
                #1 ready_i = 1'b1;
            end
        join
        repeat (10) @(negedge clk);
        chk("t5_count", emitted - e0, 4);
        chk("t5_drained", q.size(), 0);
        align();

        // 6: reset with two beats in flight
        send(v1, v1, 1'b0, ctrl_t'(5'd10));
        send(v2, v2, 1'b1, ctrl_t'(5'd11));
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t6_valid_in_reset", {valid_o_u, valid_o_s}, 2'b00);
        chk("t6_ready_in_reset", {ready_o_u, ready_o_s}, 2'b11);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t6_no_stale", valid_o_u, 0);
        end
        align();
        send(v2, v2, 1'b1, ctrl_t'(5'd12));
        wait_out(lat);
        chk("t6_post_latency", lat, LOG2N);
        chk("t6_post_y", y_u, kv('{9, 8, 7, 6, 4, 3, 2, 1}));
        align();

        // Random traffic with random backpressure
        fork
            begin
                for (int k = 0; k < 300; k++) begin
                    d = 1'($urandom_range(0, 1));
                    for (int i = 0; i < N; i++) begin
                        a[i] = (k % 3 == 0) ? DW'($urandom_range(0, 7)) : DW'($urandom_range(0, 255));
                    end
                    send(sort_rng(sort_rng(a, 0, N/2, d, 0), N/2, N/2, d, 0),
                         sort_rng(sort_rng(a, 0, N/2, d, 1), N/2, N/2, d, 1),
                         d, ctrl_t'(5'($urandom)));
                    if ($urandom_range(0, 3) == 0) align();
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 ready_i = ($urandom_range(0, 3) != 0);
                end
            end
        join
        ready_i = 1'b1;
        repeat (12) @(negedge clk);
        chk("random_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
